// File: rtl/ps2_command_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, ACK.
// Optional macro PS2_TX_ACK_CHECK_EN turns a high data line at the ACK edge into an error instead of a success.
module ps2_command_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  input  logic [7:0] the_command,
  input  logic       send_command,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic [2:0] state_dbg_o
);

  localparam int MAX_A = (START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES;
  localparam int MAX_C = (XFER_TIMEOUT > MAX_A) ? XFER_TIMEOUT : MAX_A;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_START   = 3'd2,
    S_DATA    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          dat_s1_q, dat_s2_q;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          busy_q, busy_d;
  logic          sent_q, sent_d;
  logic          err_q, err_d;
  logic          fall;

  // Line synchronizers reset to the idle-high level so reset never fakes a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_dat_in;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      frame_q  <= '0;
      idx_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      idx_q    <= idx_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      sent_q   <= sent_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    frame_d  = frame_q;
    idx_d    = idx_q;
    clk_oe_d = 1'b0;
    dat_oe_d = dat_oe_q;
    sent_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        dat_oe_d = 1'b0;
        // A request coinciding with a status pulse is dropped, not deferred.
        if (send_command && !sent_q && !err_q) begin
          frame_d  = {~^the_command, the_command};
          idx_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        dat_oe_d = 1'b0;
        if (cnt_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        dat_oe_d = 1'b1;
        if (fall) begin
          dat_oe_d = ~frame_q[0];
          idx_d    = 4'd1;
          cnt_d    = '0;
          state_d  = S_DATA;
        end else if (cnt_q == START_LAST) begin
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_ERROR;
        end
      end
      S_DATA, S_ACK, S_RELEASE: begin
        if (cnt_q == XFER_LAST) begin
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_ERROR;
        end else if (state_q == S_DATA) begin
          if (fall) begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd9) begin
              dat_oe_d = 1'b0;
              state_d  = S_ACK;
            end else begin
              dat_oe_d = ~frame_q[idx_q];
            end
          end
        end else if (state_q == S_ACK) begin
          if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
            if (dat_s2_q) begin
              err_d   = 1'b1;
              state_d = S_ERROR;
            end else begin
              state_d = S_RELEASE;
            end
`else
            state_d = S_RELEASE;
`endif
          end
        end else if (clk_s2_q && dat_s2_q) begin
          sent_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: begin
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ps2_clk_oe                    = clk_oe_q;
  assign ps2_dat_oe                    = dat_oe_q;
  assign busy                          = busy_q;
  assign command_was_sent              = sent_q;
  assign error_communication_timed_out = err_q;
  assign state_dbg_o                   = state_q;

endmodule

// File: tb/tb_ps2_command_transmitter.sv
// Directed bench for ps2_command_transmitter with a clock-generating PS/2 device model on open-collector lines.
module tb_ps2_command_transmitter;

  localparam int INH  = 50;
  localparam int STO  = 400;
  localparam int XTO  = 1500;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic [7:0] the_command = 8'h00;
  logic       send_command = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_communication_timed_out;
  logic [2:0] state_dbg;

  int checks = 0, passed = 0, fails = 0;
  int cyc = 0, sent_cnt = 0, err_cnt = 0, both_cnt = 0, busy_rises = 0;
  int err_cyc = 0, busy_rise_cyc = 0, first_fall_cyc = 0, clk_run = 0, last_run = 0;
  logic start_bit_ok = 1'b0, busy_prev = 1'b0;

  always #5 clk = ~clk;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_command_transmitter #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO)
  ) dut (
    .CLOCK_50                     (clk),
    .resetn                       (resetn),
    .ps2_clk_in                   (ps2_clk_in),
    .ps2_dat_in                   (ps2_dat_in),
    .the_command                  (the_command),
    .send_command                 (send_command),
    .ps2_clk_oe                   (ps2_clk_oe),
    .ps2_dat_oe                   (ps2_dat_oe),
    .busy                         (busy),
    .command_was_sent             (command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .state_dbg_o                  (state_dbg)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (command_was_sent) sent_cnt++;
    if (error_communication_timed_out) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (command_was_sent && error_communication_timed_out) both_cnt++;
    if (busy && !busy_prev) begin
      busy_rises++;
      busy_rise_cyc = cyc;
    end
    busy_prev = busy;
    if (ps2_clk_oe) clk_run++;
    else if (clk_run != 0) begin
      last_run     = clk_run;
      start_bit_ok = ps2_dat_oe;
      clk_run      = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] cmd);
    the_command  = cmd;
    send_command = 1'b1;
    tick();
    send_command = 1'b0;
  endtask

  task automatic wait_status(input int sent_target, input int err_target, input int limit);
    int t = 0;
    while (sent_cnt < sent_target && err_cnt < err_target && t < limit) begin
      tick();
      t++;
    end
    tick();
  endtask

  // Device: waits for the start bit, clocks n_edges, samples data on rising edges, ACKs on edge 11.
  task automatic dev_xfer(input int n_edges, input bit ack_low, input int inject_edge,
                          input int reset_edge, output logic [9:0] bits);
    int t = 0;
    bits = '0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && t < INH + 50) begin
      tick();
      t++;
    end
    chk("start_seen", (t < INH + 50), 1);
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11) dev_dat = ack_low ? 1'b0 : 1'b1;
      repeat (HALF) tick();
      dev_clk = 1'b0;
      if (e == 1) first_fall_cyc = cyc;
      if (e == inject_edge) begin
        the_command  = 8'hAA;
        send_command = 1'b1;
        tick();
        send_command = 1'b0;
      end
      if (e == reset_edge) begin
        repeat (4) tick();
        resetn = 1'b0;
        tick();
        chk("t5_rst_outs", {ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
                            error_communication_timed_out}, 0);
        resetn  = 1'b1;
        dev_clk = 1'b1;
        return;
      end
      repeat (HALF) tick();
      dev_clk = 1'b1;
      if (e <= 10) bits[e-1] = ps2_dat_in;
    end
    if (n_edges == 11) begin
      repeat (HALF) tick();
      dev_dat = 1'b1;
    end
  endtask

  initial begin
    logic [9:0] bits;
    int d;
    int rises0;

    repeat (3) tick();
    chk("rst_outs", {ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
                     error_communication_timed_out}, 0);
    chk("rst_state", state_dbg, 0);
    resetn = 1'b1;
    repeat (2) tick();

    // Test 1: 0xED with ACK.
    send(8'hED);
    chk("t1_busy_latency", busy, 1);
    chk("t1_clk_oe_latency", ps2_clk_oe, 1);
    dev_xfer(11, 1'b1, 0, 0, bits);
    chk("t1_inhibit_len", last_run, INH);
    chk("t1_start_bit", start_bit_ok, 1);
    chk("t1_frame", bits, 10'h3ED);
    wait_status(1, 1000, 300);
    chk("t1_sent", sent_cnt, 1);
    chk("t1_no_err", err_cnt, 0);
    chk("t1_idle", {busy, ps2_clk_oe, ps2_dat_oe}, 0);

    // Test 2: parity of 0x01 and 0x00.
    repeat (2) tick();
    send(8'h01);
    dev_xfer(11, 1'b1, 0, 0, bits);
    chk("t2_frame_01", bits, 10'h201);
    wait_status(2, 1000, 300);
    repeat (2) tick();
    send(8'h00);
    dev_xfer(11, 1'b1, 0, 0, bits);
    chk("t2_frame_00", bits, 10'h300);
    wait_status(3, 1000, 300);
    chk("t2_sent", sent_cnt, 3);

    // Test 3: device never clocks.
    repeat (2) tick();
    send(8'h55);
    wait_status(1000, 1, INH + STO + 100);
    chk("t3_err", err_cnt, 1);
    d = err_cyc - busy_rise_cyc;
    chk("t3_err_delay", (d >= INH + STO - 3 && d <= INH + STO + 3), 1);
    chk("t3_lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
    chk("t3_no_sent", sent_cnt, 3);

    // Test 4: device stops after 4 falling edges.
    repeat (2) tick();
    send(8'h3C);
    dev_xfer(4, 1'b1, 0, 0, bits);
    wait_status(1000, 2, XTO + 200);
    chk("t4_err", err_cnt, 2);
    d = err_cyc - first_fall_cyc;
    chk("t4_err_delay", (d >= XTO - 3 && d <= XTO + 3), 1);
    chk("t4_no_sent", sent_cnt, 3);
    chk("t4_lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);

    // Test 5: 0xF4, ignored 0xAA request mid-frame, reset during bit 5.
    repeat (2) tick();
    rises0 = busy_rises;
    send(8'hF4);
    dev_xfer(11, 1'b1, 3, 6, bits);
    chk("t5_bits_before_reset", bits[4:0], 5'b10100);
    repeat (100) tick();
    chk("t5_no_new_xfer", busy_rises, rises0 + 1);
    chk("t5_busy_low", busy, 0);
    chk("t5_no_sent", sent_cnt, 3);
    chk("t5_no_err", err_cnt, 2);

    // Test 6: device leaves data high at the ACK edge.
    send(8'hED);
    dev_xfer(11, 1'b0, 0, 0, bits);
    chk("t6_frame", bits, 10'h3ED);
    wait_status(4, 3, 300);
`ifdef PS2_TX_ACK_CHECK_EN
    chk("t6_nack_err", err_cnt, 3);
    chk("t6_nack_no_sent", sent_cnt, 3);
`else
    chk("t6_sent", sent_cnt, 4);
    chk("t6_no_err", err_cnt, 2);
`endif
    chk("exclusive_pulses", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
